login_sequencer: RTL

- Sequences the access-control datapath: captures user ID and password from the 16 toggle switches on button presses and presents each as a tagged word with a one-cycle load strobe.
- Waits for the grant/deny response, counts failed attempts, and enforces lockout.
- Sits between the button decoder's access-control vector and the access-control block.
- Feeds the process control with login status, LED drive and an LCD state code.

---
 rtl/login_sequencer.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/login_sequencer.sv
// Login sequencer: captures ID/password from the switches, presents them as tagged words to
// access control, tracks failed attempts and enforces lockout. LOGIN_IDLE_LOGOUT_EN adds inactivity logout.
module login_sequencer #(
   parameter int MAX_ATTEMPTS   = 3,
   parameter int RESP_TIMEOUT   = 16,
   parameter int DENY_HOLD      = 4,
   parameter int LOCKOUT_CYCLES = 32
`ifdef LOGIN_IDLE_LOGOUT_EN
   ,
   parameter int IDLE_LOGOUT_CYCLES = 64
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  buttons,
   input  logic [15:0] switches,
   input  logic        ac_grant,
   input  logic        ac_deny,
   output logic [17:0] ac_data,
   output logic        ac_load,
   output logic        logged_in,
   output logic        locked_out,
   output logic [1:0]  led,
   output logic [3:0]  state_code,
   output logic [3:0]  attempts
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_SEND_ID   = 3'd1,
      S_PW_ENTRY  = 3'd2,
      S_SEND_PW   = 3'd3,
      S_WAIT_RESP = 3'd4,
      S_DENIED    = 3'd5,
      S_GRANTED   = 3'd6,
      S_LOCKED    = 3'd7
   } state_t;

   localparam logic [15:0] RESP_LAST = 16'(RESP_TIMEOUT - 1);
   localparam logic [15:0] DENY_LAST = 16'(DENY_HOLD - 1);
   localparam logic [15:0] LOCK_LAST = 16'(LOCKOUT_CYCLES - 1);
   localparam logic [3:0]  ATT_MAX   = 4'(MAX_ATTEMPTS);

   logic enter, cancel, logout;
   assign enter  = buttons[0];
   assign cancel = buttons[1];
   assign logout = buttons[2];

   state_t      state_q, state_d;
   logic [15:0] id_q, id_d;
   logic [15:0] pw_q, pw_d;
   logic [15:0] timer_q, timer_d, timer_sat;
   logic [3:0]  attempts_q, attempts_d;
   logic        fail;

   logic [17:0] ac_data_q, ac_data_d;
   logic        ac_load_q, ac_load_d;
   logic        logged_in_q, logged_in_d;
   logic        locked_out_q, locked_out_d;
   logic [1:0]  led_q, led_d;
   logic [3:0]  state_code_q, state_code_d;

`ifdef LOGIN_IDLE_LOGOUT_EN
   localparam logic [15:0] IDLE_LAST = 16'(IDLE_LOGOUT_CYCLES - 1);
   logic [15:0] idle_q, idle_d;
`endif

   assign timer_sat = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;

   always_comb begin
      state_d    = state_q;
      id_d       = id_q;
      pw_d       = pw_q;
      timer_d    = timer_q;
      attempts_d = attempts_q;
      fail       = 1'b0;
`ifdef LOGIN_IDLE_LOGOUT_EN
      idle_d     = idle_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (enter) begin
               id_d    = switches;
               state_d = S_SEND_ID;
            end
         end
         S_SEND_ID: state_d = S_PW_ENTRY;
         S_PW_ENTRY: begin
            if (cancel) begin
               state_d = S_IDLE;
            end else if (enter) begin
               pw_d    = switches;
               state_d = S_SEND_PW;
            end
         end
         S_SEND_PW: begin
            timer_d = '0;
            state_d = S_WAIT_RESP;
         end
         S_WAIT_RESP: begin
            timer_d = timer_sat;
            if (ac_deny) begin
               fail = 1'b1;
            end else if (ac_grant) begin
               state_d    = S_GRANTED;
               attempts_d = '0;
`ifdef LOGIN_IDLE_LOGOUT_EN
               idle_d     = '0;
`endif
            end else if (timer_q >= RESP_LAST) begin
               fail = 1'b1;
            end
         end
         S_DENIED: begin
            if (timer_q >= DENY_LAST) state_d = S_IDLE;
            else                      timer_d = timer_sat;
         end
         S_GRANTED: begin
            if (logout) begin
               state_d = S_IDLE;
            end
`ifdef LOGIN_IDLE_LOGOUT_EN
            else if (|buttons) begin
               idle_d = '0;
            end else if (idle_q >= IDLE_LAST) begin
               state_d = S_IDLE;
            end else begin
               idle_d = idle_q + 16'd1;
            end
`endif
         end
         S_LOCKED: begin
            if (timer_q >= LOCK_LAST) begin
               state_d    = S_IDLE;
               attempts_d = '0;
            end else begin
               timer_d = timer_sat;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Failure from deny or timeout: the hold timer for DENIED/LOCKED starts from zero.
      if (fail) begin
         attempts_d = (attempts_q >= ATT_MAX) ? ATT_MAX : attempts_q + 4'd1;
         timer_d    = '0;
         state_d    = (attempts_d >= ATT_MAX) ? S_LOCKED : S_DENIED;
      end

      if (state_d == S_IDLE) begin
         id_d = '0;
         pw_d = '0;
      end
   end

   // Outputs are decoded from the next state so they are registered yet aligned with it.
   always_comb begin
      ac_load_d    = (state_d == S_SEND_ID) || (state_d == S_SEND_PW);
      ac_data_d    = '0;
      if (state_d == S_SEND_ID) ac_data_d = {2'b01, id_d};
      if (state_d == S_SEND_PW) ac_data_d = {2'b10, pw_d};
      logged_in_d  = (state_d == S_GRANTED);
      locked_out_d = (state_d == S_LOCKED);
      led_d        = 2'b00;
      if (state_d == S_DENIED || state_d == S_LOCKED) led_d = 2'b01;
      if (state_d == S_GRANTED)                       led_d = 2'b10;
      state_code_d = {1'b0, state_d};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         id_q         <= '0;
         pw_q         <= '0;
         timer_q      <= '0;
         attempts_q   <= '0;
         ac_data_q    <= '0;
         ac_load_q    <= 1'b0;
         logged_in_q  <= 1'b0;
         locked_out_q <= 1'b0;
         led_q        <= 2'b00;
         state_code_q <= '0;
`ifdef LOGIN_IDLE_LOGOUT_EN
         idle_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         id_q         <= id_d;
         pw_q         <= pw_d;
         timer_q      <= timer_d;
         attempts_q   <= attempts_d;
         ac_data_q    <= ac_data_d;
         ac_load_q    <= ac_load_d;
         logged_in_q  <= logged_in_d;
         locked_out_q <= locked_out_d;
         led_q        <= led_d;
         state_code_q <= state_code_d;
`ifdef LOGIN_IDLE_LOGOUT_EN
         idle_q       <= idle_d;
`endif
      end
   end

   assign ac_data    = ac_data_q;
   assign ac_load    = ac_load_q;
   assign logged_in  = logged_in_q;
   assign locked_out = locked_out_q;
   assign led        = led_q;
   assign state_code = state_code_q;
   assign attempts   = attempts_q;

endmodule
